// File: rtl/rr_arb_pkg.sv
// Shared types for the 4-way round-robin stream arbiter.
// Holds the select type, FSM states and requester count.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: first active request at or after ptr.
// Purely combinational; grant is don't-care when any is low.
import rr_arb_pkg::*;

module rr_pick_4 (
  input  logic [3:0] req,
  input  sel_t       ptr,
  output logic       any,
  output sel_t       grant
);

  sel_t idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    any   = 1'b0;
    grant = ptr;
    idx   = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter_4.sv
// 4:1 round-robin packet arbiter with a one-entry output register.
// Grant is held for a whole packet; priority rotates after each last beat.
import rr_arb_pkg::*;

module rr_stream_arbiter_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_sel,
  output logic             busy
);

  arb_state_t state_q, state_d;
  sel_t       lock_sel_q, lock_sel_d;
  sel_t       ptr_q, ptr_d;
  logic       out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  sel_t       out_sel_q, out_sel_d;

  logic       pick_any;
  sel_t       pick_grant;
  sel_t       grant;
  logic       grant_ok;
  logic       load;
  logic       accept;
  logic [WIDTH-1:0] mux_data;

  rr_pick_4 u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .any   (pick_any),
    .grant (pick_grant)
  );

  always_comb begin
    load     = !out_valid_q || out_ready;
    grant    = (state_q == LOCKED) ? lock_sel_q : pick_grant;
    grant_ok = rst_n && ((state_q == LOCKED) || pick_any);
    in_ready = '0;
    if (grant_ok && load) in_ready[grant] = 1'b1;
    accept   = in_valid[grant] && in_ready[grant];
    mux_data = (grant == 2'd0) ? in_data0 :
               (grant == 2'd1) ? in_data1 :
               (grant == 2'd2) ? in_data2 :
                                 in_data3;
  end

  always_comb begin
    state_d     = state_q;
    lock_sel_d  = lock_sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = in_last[grant];
      out_sel_d   = grant;
      if (in_last[grant]) begin
        state_d = IDLE;
        ptr_d   = grant + 2'd1;
      end else begin
        state_d    = LOCKED;
        lock_sel_d = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_sel_q  <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_sel_q  <= lock_sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == LOCKED);

endmodule
